// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC angle front end and core: IEEE-754
// single-precision field layout, input classification and default widths.
package cordic_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  // Default fixed-point format shared with the CORDIC core (Q1.22 in 24 bits)
  localparam int CORDIC_OUT_W     = 24;
  localparam int CORDIC_FRAC_BITS = 22;

  // Width of the signed alignment shift produced by the unpack stage
  localparam int SH_W = 10;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

endpackage

// File: rtl/cordic_angle_fix_conv_if.sv
// Sample-in / result-out bundle of the float-to-fixed angle converter.
// master = upstream feeder side, slave = converter side.
interface cordic_angle_fix_conv_if #(
  parameter int OUT_W = cordic_pkg::CORDIC_OUT_W
);
  logic                    in_valid;
  logic [31:0]             angle_float;
  logic                    out_valid;
  logic signed [OUT_W-1:0] angle_fixed;
  logic                    overflow;
  logic                    invalid;

  modport master (
    output in_valid, angle_float,
    input  out_valid, angle_fixed, overflow, invalid
  );

  modport slave (
    input  in_valid, angle_float,
    output out_valid, angle_fixed, overflow, invalid
  );
endinterface

// File: rtl/cordic_angle_fix_conv_fx_round_shift.sv
// Combinational barrel shifter with a signed shift amount: left shifts
// flag overflow from the shift amount itself, right shifts round half-up.
module fx_round_shift #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 24,
  parameter int SH_W  = 10
) (
  input  logic [IN_W-1:0]        m,
  input  logic signed [SH_W-1:0] sh,
  output logic [OUT_W:0]         mag,
  output logic                   ovf
);

  // m carries a leading one, so the top result bit sits at IN_W-1+sh; it
  // must stay below bit OUT_W-1 to fit the magnitude field.
  localparam logic signed [SH_W-1:0] SH_FIT_MAX   = SH_W'(OUT_W - 1 - IN_W);
  localparam logic signed [SH_W-1:0] SH_MIN_ROUND = SH_W'(-IN_W);

  // Right shift by r with the half-LSB added first; one extra bit keeps the carry.
  function automatic logic [IN_W:0] round_shr(input logic [IN_W-1:0] v,
                                              input logic [SH_W-1:0] r);
    logic [IN_W:0] half;
    half = (IN_W+1)'(1) << (r - SH_W'(1));
    return ({1'b0, v} + half) >> r;
  endfunction

  // Pick left shift, rounded right shift, or flush depending on sign/size of sh.
  always_comb begin
    mag = '0;
    ovf = 1'b0;
    if (!sh[SH_W-1]) begin
      if (sh > SH_FIT_MAX) ovf = 1'b1;
      else                 mag = (OUT_W+1)'(m) << sh[SH_W-2:0];
    end else if (sh >= SH_MIN_ROUND) begin
      mag = (OUT_W+1)'(round_shr(m, SH_W'(-sh)));
    end
  end

endmodule

// File: rtl/cordic_angle_fix_conv.sv
// IEEE-754 single-precision radians to signed fixed point for the CORDIC
// core. Three registered stages (unpack/classify, align/round,
// saturate/sign) sharing one global clock enable with the core.
module cordic_angle_fix_conv
  import cordic_pkg::*;
#(
  parameter int OUT_W     = CORDIC_OUT_W,
  parameter int FRAC_BITS = CORDIC_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  cordic_angle_fix_conv_if.slave  bus
);

  localparam logic [OUT_W:0]   MAG_LIMIT = (OUT_W+1)'(1) << (OUT_W-1);
  localparam logic [OUT_W-1:0] MAG_MAX   = {1'b0, {(OUT_W-1){1'b1}}};

  // Clamp to the symmetric range; anything at or above 2^(OUT_W-1) saturates.
  function automatic logic sat_hit(input logic [OUT_W:0] mag, input logic ovf);
    return ovf || (mag >= MAG_LIMIT);
  endfunction

  function automatic logic [OUT_W-1:0] sat_mag(input logic [OUT_W:0] mag, input logic ovf);
    return sat_hit(mag, ovf) ? MAG_MAX : mag[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_sign(input logic neg,
                                                         input logic [OUT_W-1:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  logic                    vld_p1_q, vld_p2_q;
  logic                    sign_p1_d, sign_p1_q, sign_p2_q;
  cls_e                    cls_p1_d, cls_p1_q, cls_p2_q;
  logic [FP_MAN_W:0]       man_p1_d, man_p1_q;
  logic signed [SH_W-1:0]  sh_p1_d, sh_p1_q;
  logic [OUT_W:0]          mag_p2_d, mag_p2_q;
  logic                    ovf_p2_d, ovf_p2_q;
  logic                    out_valid_d, out_valid_q;
  logic signed [OUT_W-1:0] angle_fixed_d, angle_fixed_q;
  logic                    overflow_d, overflow_q;
  logic                    invalid_d, invalid_q;
  logic [FP_EXP_W-1:0]     exp_w;
  logic [FP_MAN_W-1:0]     frac_w;

  // ---- Stage 1: unpack fields, classify, derive alignment shift
  always_comb begin
    exp_w     = bus.angle_float[30:23];
    frac_w    = bus.angle_float[22:0];
    sign_p1_d = bus.angle_float[31];
    man_p1_d  = {1'b1, frac_w};
    sh_p1_d   = {2'b00, exp_w} - SH_W'(FP_BIAS - FRAC_BITS + FP_MAN_W);
    if (exp_w == '0)       cls_p1_d = CLS_ZERO;
    else if (&exp_w)       cls_p1_d = (frac_w == '0) ? CLS_INF : CLS_NAN;
    else                   cls_p1_d = CLS_NORM;
  end

  // ---- Stage 2: align and round the mantissa
  fx_round_shift #(
    .IN_W  (FP_MAN_W + 1),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_round_shift (
    .m   (man_p1_q),
    .sh  (sh_p1_q),
    .mag (mag_p2_d),
    .ovf (ovf_p2_d)
  );

  // ---- Stage 3: saturate, apply sign, resolve flags; bubbles hold the old result
  always_comb begin
    out_valid_d   = vld_p2_q;
    angle_fixed_d = angle_fixed_q;
    overflow_d    = overflow_q;
    invalid_d     = invalid_q;
    if (vld_p2_q) begin
      unique case (cls_p2_q)
        CLS_NAN: begin
          angle_fixed_d = '0;
          overflow_d    = 1'b0;
          invalid_d     = 1'b1;
        end
        CLS_INF: begin
          angle_fixed_d = apply_sign(sign_p2_q, MAG_MAX);
          overflow_d    = 1'b1;
          invalid_d     = 1'b0;
        end
        CLS_NORM: begin
          angle_fixed_d = apply_sign(sign_p2_q, sat_mag(mag_p2_q, ovf_p2_q));
          overflow_d    = sat_hit(mag_p2_q, ovf_p2_q);
          invalid_d     = 1'b0;
        end
        default: begin
          angle_fixed_d = '0;
          overflow_d    = 1'b0;
          invalid_d     = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers: cleared asynchronously, frozen when clk_en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      angle_fixed_q <= '0;
      overflow_q    <= 1'b0;
      invalid_q     <= 1'b0;
    end else if (clk_en) begin
      vld_p1_q      <= bus.in_valid;
      vld_p2_q      <= vld_p1_q;
      out_valid_q   <= out_valid_d;
      angle_fixed_q <= angle_fixed_d;
      overflow_q    <= overflow_d;
      invalid_q     <= invalid_d;
    end
  end

  // Internal stage data: no reset, only loaded when a valid sample occupies the slot.
  always_ff @(posedge clk) begin
    if (clk_en && bus.in_valid) begin
      sign_p1_q <= sign_p1_d;
      cls_p1_q  <= cls_p1_d;
      man_p1_q  <= man_p1_d;
      sh_p1_q   <= sh_p1_d;
    end
    if (clk_en && vld_p1_q) begin
      sign_p2_q <= sign_p1_q;
      cls_p2_q  <= cls_p1_q;
      mag_p2_q  <= mag_p2_d;
      ovf_p2_q  <= ovf_p2_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.angle_fixed = angle_fixed_q;
  assign bus.overflow    = overflow_q;
  assign bus.invalid     = invalid_q;

endmodule

// File: tb/tb_cordic_angle_fix_conv.sv
// Directed bench for the float-to-fixed angle converter; expected codes
// are hand-derived from the IEEE-754 encodings in each task.
module tb_cordic_angle_fix_conv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  cordic_angle_fix_conv_if #(.OUT_W(24)) bus ();

  cordic_angle_fix_conv #(.OUT_W(24), .FRAC_BITS(22)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // one rising edge, then settle 1 time unit before driving/sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one valid sample followed by two bubble edges: the result is on the outputs afterwards
  task automatic send_one(input logic [31:0] f);
    bus.in_valid    = 1'b1;
    bus.angle_float = f;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clk_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.angle_float = 32'h0;
    step();
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.angle_fixed !== 24'h0 ||
        bus.overflow !== 1'b0 || bus.invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h o=%b i=%b want v=0 d=000000 o=0 i=0",
               bus.out_valid, bus.angle_fixed, bus.overflow, bus.invalid);
    end
    #2 rst = 1'b1;
    clk_en = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1;
    bus.angle_float = 32'h3F7CAC08;
    step();
    bus.in_valid = 1'b0;
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: got out_valid=%b after 2 edges want 0", bus.out_valid);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.angle_fixed !== 24'h3F2B02 ||
        bus.overflow !== 1'b0 || bus.invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_0p987: got v=%b d=%h o=%b i=%b want v=1 d=3f2b02 o=0 i=0",
               bus.out_valid, bus.angle_fixed, bus.overflow, bus.invalid);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.angle_fixed !== 24'h3F2B02) begin
      n_fail++;
      $display("FAIL basic_bubble: got v=%b d=%h want v=0 d=3f2b02",
               bus.out_valid, bus.angle_fixed);
    end
  endtask

  task automatic test_stall();
    bus.in_valid = 1'b1;
    bus.angle_float = 32'h3F0B851F;
    step();
    bus.in_valid = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.angle_fixed !== 24'h3F2B02) begin
        n_fail++;
        $display("FAIL stall_freeze[%0d]: got v=%b d=%h want v=0 d=3f2b02",
                 i, bus.out_valid, bus.angle_fixed);
      end
    end
    clk_en = 1'b1;
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early: got out_valid=%b on 2nd enabled edge want 0", bus.out_valid);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.angle_fixed !== 24'h22E148) begin
      n_fail++;
      $display("FAIL stall_result: got v=%b d=%h want v=1 d=22e148",
               bus.out_valid, bus.angle_fixed);
    end
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.angle_fixed !== 24'h22E148) begin
        n_fail++;
        $display("FAIL stall_hold_valid[%0d]: got v=%b d=%h want v=1 d=22e148",
                 i, bus.out_valid, bus.angle_fixed);
      end
    end
    clk_en = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.angle_float = 32'hBD8F5C29;
    step();
    bus.angle_float = 32'h3F0B851F;
    step();
    bus.in_valid = 1'b0;
    step();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.angle_fixed !== 24'hFB851F || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b d=%h o=%b want v=1 d=fb851f o=0",
               bus.out_valid, bus.angle_fixed, bus.overflow);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.angle_fixed !== 24'h22E148) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b d=%h want v=1 d=22e148",
               bus.out_valid, bus.angle_fixed);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.angle_fixed !== 24'h22E148) begin
      n_fail++;
      $display("FAIL b2b_bubble: got v=%b d=%h want v=0 d=22e148",
               bus.out_valid, bus.angle_fixed);
    end
  endtask

  // input, expected code, expected overflow, expected invalid
  task automatic test_boundaries();
    logic [31:0] vin  [8] = '{32'h40000000, 32'hFF800000, 32'h7FC00000, 32'h00000001,
                              32'h80000000, 32'h3FFFFFFF, 32'h7F800000, 32'hFFC00001};
    logic [23:0] vexp [8] = '{24'h7FFFFF, 24'h800001, 24'h000000, 24'h000000,
                              24'h000000, 24'h7FFFFF, 24'h7FFFFF, 24'h000000};
    logic        vovf [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vinv [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      send_one(vin[i]);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.angle_fixed !== vexp[i] ||
          bus.overflow !== vovf[i] || bus.invalid !== vinv[i]) begin
        n_fail++;
        $display("FAIL boundary_%h: got v=%b d=%h o=%b i=%b want v=1 d=%h o=%b i=%b",
                 vin[i], bus.out_valid, bus.angle_fixed, bus.overflow, bus.invalid,
                 vexp[i], vovf[i], vinv[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin  [5] = '{32'h33000000, 32'h34800000, 32'h3F7FFFFF,
                              32'hBF7CAC08, 32'hB4800000};
    logic [23:0] vexp [5] = '{24'h000000, 24'h000001, 24'h400000,
                              24'hC0D4FE, 24'hFFFFFF};
    for (int i = 0; i < 5; i++) begin
      send_one(vin[i]);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.angle_fixed !== vexp[i] ||
          bus.overflow !== 1'b0 || bus.invalid !== 1'b0) begin
        n_fail++;
        $display("FAIL round_%h: got v=%b d=%h o=%b i=%b want v=1 d=%h o=0 i=0",
                 vin[i], bus.out_valid, bus.angle_fixed, bus.overflow, bus.invalid, vexp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.in_valid = 1'b1;
    bus.angle_float = 32'h3F7CAC08;
    step();
    bus.angle_float = 32'hBD8F5C29;
    step();
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.angle_fixed !== 24'h0 ||
        bus.overflow !== 1'b0 || bus.invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_now: got v=%b d=%h o=%b i=%b want v=0 d=000000 o=0 i=0",
               bus.out_valid, bus.angle_fixed, bus.overflow, bus.invalid);
    end
    step();
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.angle_fixed !== 24'h0) begin
        n_fail++;
        $display("FAIL async_reset_stale[%0d]: got v=%b d=%h want v=0 d=000000",
                 i, bus.out_valid, bus.angle_fixed);
      end
    end
    send_one(32'h3F0B851F);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.angle_fixed !== 24'h22E148) begin
      n_fail++;
      $display("FAIL async_reset_recover: got v=%b d=%h want v=1 d=22e148",
               bus.out_valid, bus.angle_fixed);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.angle_float = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_boundaries();
    test_rounding();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_angle_fix_conv.md
Name: cordic_angle_fix_conv

Overview:
- Upstream feeder for the unrolled CORDIC core.
- Converts an IEEE-754 single-precision angle in radians (from the Nios II custom-instruction dataa path) into signed fixed point for the CORDIC datapath.
- Three-stage pipeline with valid propagation and a global clock enable, matching the stall semantics of the core.
- Flags out-of-range and invalid inputs, and saturates the result.

Parameters:
- OUT_W, 24: output width, two's complement.
- FRAC_BITS, 22: fractional bits of the output. Default gives a Q1.22 signed range of about [-2, 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. 0 clears all state immediately.
- clk_en  in  1  global enable. When 0, every pipeline register holds, including the outputs.
- in_valid  in  1  angle_float is sampled this cycle (only when clk_en=1).
- angle_float  in  32  IEEE-754 single-precision angle.
- out_valid  out  1  angle_fixed, overflow and invalid are valid.
- angle_fixed  out  OUT_W  signed fixed-point angle, round-half-up on magnitude, sign applied after rounding.
- overflow  out  1  result was saturated (|x| too large or ±Inf).
- invalid  out  1  input was NaN; angle_fixed forced to 0.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits = 0. out_valid=0, angle_fixed=0, overflow=0, invalid=0. Reset mid-stream discards all in-flight data with no partial output. First sample is accepted on the first enabled edge after rst goes high.
- Latency: exactly 3 rising edges with clk_en=1, from in_valid sampled to out_valid=1.
- Throughput: 1 sample per enabled cycle.
- Stall: cycles with clk_en=0 do not count toward latency and freeze every register. Outputs hold their last values, including out_valid.
- out_valid is high for one enabled cycle per accepted input. in_valid=0 inserts a bubble; out_valid=0 for that slot, and angle_fixed and the flags hold their previous values.
- S1 (unpack/classify), registered:
  - sign = bit31; exp = bits30:23; m = {1, bits22:0}.
  - Class ZERO when exp=0, which includes denormals (flushed to zero).
  - Class INF when exp=255 and fraction=0.
  - Class NAN when exp=255 and fraction≠0.
  - Otherwise class NORM, with shift sh = (exp-127) + FRAC_BITS - 23, signed, 10 bits.
- S2 (align/round), registered magnitude in OUT_W+1 bits plus a pre-saturation overflow bit:
  - sh ≥ 0: mag = m << sh. Set overflow if the result does not fit OUT_W-1 bits; detect this from sh directly, not from a truncated shift.
  - sh in [-24, -1]: r = -sh; mag = (m + 2^(r-1)) >> r.
  - sh ≤ -25: mag = 0.
- S3 (saturate/sign), output registers:
  - If overflow or INF: mag = 2^(OUT_W-1)-1 and overflow=1.
  - A rounding carry to exactly 2^(OUT_W-1) also saturates and sets overflow=1.
  - Saturation is symmetric: the most negative code is never produced.
  - Output = sign ? -mag : mag.
  - ZERO gives 0 with both flags cleared.
  - NAN gives 0 with invalid=1 and overflow=0.
- Negative zero maps to 0.
- Sign is applied after rounding, so -x always yields the exact negation of +x.

Decomposition:
- Shared package cordic_pkg holds:
  - float field constants: FP_EXP_W=8, FP_MAN_W=23, FP_BIAS=127;
  - a class enum: CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN;
  - the default OUT_W and FRAC_BITS, so they are shared with the CORDIC core.
- One sub-module, fx_round_shift: a combinational signed-amount barrel shifter with round-half-up and overflow detect, used in S2. Everything else stays inline.

Test Plan:
- Reset, then clk_en=1 and in_valid=1 with 0x3F7CAC08 (0.987): after 3 edges angle_fixed=0x3F2B02, out_valid=1, overflow=0, invalid=0.
- Back-to-back 0xBD8F5C29 (-0.07) then 0x3F0B851F (0.545): outputs 0xFB851F then 0x22E148 on consecutive cycles. Then a bubble gives out_valid=0 with data held.
- 0.545 issued, then clk_en=0 for 5 cycles after the first edge: outputs and out_valid frozen. Result 0x22E148 appears on the 3rd enabled edge, not before.
- Boundaries:
  - 0x40000000 (2.0) gives 0x7FFFFF with overflow=1.
  - 0xFF800000 (-Inf) gives 0x800001 with overflow=1.
  - 0x7FC00000 (NaN) gives 0 with invalid=1.
  - 0x00000001 (denormal) and 0x80000000 (-0) each give 0 with no flags.
- Rounding: 0x33000000 (2^-25) gives 0. 0x34800000 (2^-22) gives 0x000001. 0x3F7FFFFF (just below 1) gives 0x400000.
- rst pulsed low asynchronously (between edges) with 2 samples in flight: out_valid and outputs go to 0 immediately, no stale output after release. A new sample 3 enabled edges later is correct.
